// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants and digit index type
package seg7_pkg;
  typedef logic [1:0] digit_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg7_hex_enc.sv
// seg7_hex_enc: nibble to active-low {g..a} segment pattern
module seg7_hex_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nib];
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scan driver with guard and leading-zero blanking
module display_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        lz_en,
  output digit_t      digit_sel,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        scan_tick
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] presc, guard, guard_nxt;
  logic [15:0] data;
  logic [3:0] dp, blank, nib;
  logic [6:0] hex;
  logic tick, lead, dark;
  digit_t idx_nxt;
  // outputs are computed for the index being entered, so seg_n always matches digit_sel
  always_comb begin
    tick = presc == PW'(DIV - 1);
    idx_nxt = tick ? digit_sel + 2'd1 : digit_sel;
    guard_nxt = tick ? PW'(GUARD) : (guard != '0 ? guard - PW'(1) : guard);
    nib = data[{idx_nxt, 2'b00} +: 4];
    lead = (idx_nxt == 2'd3) ? ~|data[15:12] :
           (idx_nxt == 2'd2) ? ~|data[15:8]  :
           (idx_nxt == 2'd1) ? ~|data[15:4]  : 1'b0;
    dark = guard_nxt != '0 || blank[idx_nxt];
  end
  seg7_hex_enc u_enc (.nib(nib), .seg(hex));
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      guard     <= '0;
      digit_sel <= '0;
      scan_tick <= 1'b0;
      seg_n     <= SEG_BLANK;
      dp_n      <= 1'b1;
      data      <= '0;
      dp        <= '0;
      blank     <= 4'hF;
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      guard     <= guard_nxt;
      digit_sel <= idx_nxt;
      scan_tick <= tick;
      seg_n     <= (dark || (lz_en && lead)) ? SEG_BLANK : hex;
      dp_n      <= dark | ~dp[idx_nxt];
      if (load) begin
        data  <= data_in;
        dp    <= dp_in;
        blank <= blank_in;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard plus table-driven checks on two builds (DIV=4/GUARD=1 and DIV=3/GUARD=0)
module tb_display_scan_ctrl;
  logic clk = 0;
  logic rst = 1, load = 0, lz_en = 0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic [1:0] sel0, sel1;
  logic [6:0] seg0, seg1;
  logic dpn0, dpn1, tk0, tk1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIV(4), .GUARD(1)) u0 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .digit_sel(sel0), .seg_n(seg0), .dp_n(dpn0), .scan_tick(tk0));
  display_scan_ctrl #(.DIV(3), .GUARD(0)) u1 (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .digit_sel(sel1), .seg_n(seg1), .dp_n(dpn1), .scan_tick(tk1));

  typedef struct {
    int presc; int guard; logic [1:0] idx;
    logic [15:0] data; logic [3:0] dp; logic [3:0] blank;
    logic [6:0] seg; logic dpn; logic tick;
  } mdl_t;
  typedef struct {
    logic [1:0] sel0; logic [6:0] seg0; logic dpn0; logic tk0;
    logic [1:0] sel1; logic [6:0] seg1; logic dpn1; logic tk1;
  } exp_t;
  typedef struct {
    logic [15:0] data; logic [3:0] dp; logic [3:0] bl; logic lz;
    logic [3:0][6:0] seg; logic [3:0] dpn;
  } vec_t;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  mdl_t m0, m1;
  exp_t q[$];
  vec_t vt[8];

  function automatic mdl_t adv(mdl_t s, logic r, logic ld, logic [15:0] d, logic [3:0] p,
                               logic [3:0] b, logic lz, int div, int grd);
    mdl_t n = s;
    logic t;
    int k;
    if (r) begin
      n = '{0, 0, 2'd0, 16'h0, 4'h0, 4'hF, 7'h7F, 1'b1, 1'b0};
      return n;
    end
    t = (s.presc == div - 1);
    n.presc = t ? 0 : s.presc + 1;
    n.idx = t ? s.idx + 2'd1 : s.idx;
    n.guard = t ? grd : (s.guard > 0 ? s.guard - 1 : 0);
    n.tick = t;
    k = int'(n.idx);
    if (n.guard > 0 || s.blank[k]) begin
      n.seg = 7'h7F; n.dpn = 1'b1;
    end else if (lz && k > 0 && (s.data >> (4 * k)) == 16'h0) begin
      n.seg = 7'h7F; n.dpn = ~s.dp[k];
    end else begin
      n.seg = hex_tbl[(s.data >> (4 * k)) & 16'hF]; n.dpn = ~s.dp[k];
    end
    if (ld) begin
      n.data = d; n.dp = p; n.blank = b;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    m0 = adv(m0, rst, load, data_in, dp_in, blank_in, lz_en, 4, 1);
    m1 = adv(m1, rst, load, data_in, dp_in, blank_in, lz_en, 3, 0);
    q.push_back('{m0.idx, m0.seg, m0.dpn, m0.tick, m1.idx, m1.seg, m1.dpn, m1.tick});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sel0", 32'(sel0), 32'(e.sel0));
    chk("seg0", 32'(seg0), 32'(e.seg0));
    chk("dpn0", 32'(dpn0), 32'(e.dpn0));
    chk("tick0", 32'(tk0), 32'(e.tk0));
    chk("sel1", 32'(sel1), 32'(e.sel1));
    chk("seg1", 32'(seg1), 32'(e.seg1));
    chk("dpn1", 32'(dpn1), 32'(e.dpn1));
    chk("tick1", 32'(tk1), 32'(e.tk1));
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    load = 1; data_in = d; dp_in = p; blank_in = b;
    step();
    load = 0;
  endtask

  initial begin
    int cnt, last, found;
    vt[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
    vt[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1111};
    vt[2] = '{16'h0040, 4'b0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h19, 7'h40}, 4'b1111};
    vt[3] = '{16'h3456, 4'b1001, 4'b0000, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0110};
    vt[4] = '{16'h789B, 4'b0100, 4'b0100, 1'b0, {7'h78, 7'h7F, 7'h10, 7'h03}, 4'b1111};
    vt[5] = '{16'hCDE0, 4'b0000, 4'b0000, 1'b1, {7'h46, 7'h21, 7'h06, 7'h40}, 4'b1111};
    vt[6] = '{16'h0005, 4'b1111, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b0000};
    vt[7] = '{16'h0F00, 4'b0000, 4'b0000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b1111};

    // reset and idle scan
    rst = 1;
    repeat (3) step();
    rst = 0;
    chk("rst_sel", 32'(sel0), 32'd0);
    chk("rst_seg", 32'(seg0), 32'h7F);
    chk("rst_dpn", 32'(dpn0), 32'd1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (tk0) cnt++;
      chk("idle_dark", 32'(seg0), 32'h7F);
    end
    chk("idle_ticks", cnt, 4);

    // table-driven display patterns
    for (int v = 0; v < 8; v++) begin
      lz_en = vt[v].lz;
      do_load(vt[v].data, vt[v].dp, vt[v].bl);
      step();
      for (int c = 0; c < 8; c++) begin
        step();
        if (m0.guard == 0) begin
          chk($sformatf("tbl%0d_seg", v), 32'(seg0), 32'(vt[v].seg[m0.idx]));
          chk($sformatf("tbl%0d_dpn", v), 32'(dpn0), 32'(vt[v].dpn[m0.idx]));
        end else begin
          chk($sformatf("tbl%0d_guard", v), 32'(seg0), 32'h7F);
        end
      end
    end

    // GUARD=0 build: clean wrap, one tick per DIV cycles, never dark
    lz_en = 0;
    do_load(16'h12AF, 4'b0100, 4'b0000);
    step();
    cnt = 0; last = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("g0_lit", 32'(seg1 == 7'h7F), 32'd0);
      if (tk1) begin
        if (last >= 0) chk("g0_period", i - last, 3);
        last = i;
        cnt++;
      end
    end
    chk("g0_ticks", cnt, 20);

    // load coincident with tick into digit1 on the GUARD=0 build
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m1.presc == 2 && m1.idx == 0) found = 1;
      else step();
    end
    chk("coin_found", found, 1);
    do_load(16'h12AF, 4'b0010, 4'b0010);
    chk("coin_sel", 32'(sel1), 32'd1);
    chk("coin_old", 32'(seg1), 32'h08);
    step();
    chk("coin_new_seg", 32'(seg1), 32'h7F);
    chk("coin_new_dpn", 32'(dpn1), 32'd1);

    // mid-scan reset on digit 2 with prescaler at 2
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m0.presc == 2 && m0.idx == 2) found = 1;
      else step();
    end
    chk("mid_found", found, 1);
    chk("mid_pre_sel", 32'(sel0), 32'd2);
    rst = 1;
    step();
    rst = 0;
    chk("mid_sel", 32'(sel0), 32'd0);
    chk("mid_seg", 32'(seg0), 32'h7F);
    chk("mid_tick", 32'(tk0), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mid_dark0", 32'(seg0), 32'h7F);
      chk("mid_dark1", 32'(seg1), 32'h7F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
